// File: rtl/dadda_pkg.sv
// dadda_pkg: shared state encoding and step schedule for the iterative 16x16 multiplier.
package dadda_pkg;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  localparam int MUL_STEPS = 4;
  localparam int ACC_W = 32;
  localparam int STEP_SHIFT [MUL_STEPS] = '{0, 8, 8, 16};
  // bit k set: step k takes the upper byte of that operand
  localparam logic [MUL_STEPS-1:0] A_HI = 4'b1010;
  localparam logic [MUL_STEPS-1:0] B_HI = 4'b1100;
endpackage

// File: rtl/dadda_8.sv
// dadda_8: 8x8 unsigned multiplier, Dadda column reduction (heights 6,4,3,2) then a final adder.
module dadda_8 (
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic [15:0] pp
);
  always_comb begin
    logic [7:0] c [17];
    logic [7:0] n [17];
    int h [17];
    int nh [17];
    int u;
    int d;
    logic [7:0] t;
    logic [15:0] r0;
    logic [15:0] r1;
    for (int i = 0; i < 17; i++) begin
      c[i] = '0;
      h[i] = 0;
    end
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        c[i+j] = c[i+j] | ({7'b0, x[i] & y[j]} << h[i+j]);
        h[i+j] = h[i+j] + 1;
      end
    // each column is packed from bit 0; heights are elaboration constants
    for (int s = 0; s < 4; s++) begin
      d = s == 0 ? 6 : s == 1 ? 4 : s == 2 ? 3 : 2;
      for (int i = 0; i < 17; i++) begin
        n[i] = '0;
        nh[i] = 0;
      end
      for (int i = 0; i < 16; i++) begin
        u = 0;
        for (int k = 0; k < 4; k++) begin
          t = c[i] >> u;
          if (h[i] - u + nh[i] > d + 1) begin
            n[i] = n[i] | ({7'b0, t[0] ^ t[1] ^ t[2]} << nh[i]);
            nh[i] = nh[i] + 1;
            n[i+1] = n[i+1] | ({7'b0, (t[0] & t[1]) | (t[2] & (t[0] ^ t[1]))} << nh[i+1]);
            nh[i+1] = nh[i+1] + 1;
            u = u + 3;
          end else if (h[i] - u + nh[i] == d + 1) begin
            n[i] = n[i] | ({7'b0, t[0] ^ t[1]} << nh[i]);
            nh[i] = nh[i] + 1;
            n[i+1] = n[i+1] | ({7'b0, t[0] & t[1]} << nh[i+1]);
            nh[i+1] = nh[i+1] + 1;
            u = u + 2;
          end
        end
        t = c[i] >> u;
        for (int k = 0; k < 8; k++)
          if (k < h[i] - u) begin
            n[i] = n[i] | ({7'b0, t[0]} << nh[i]);
            nh[i] = nh[i] + 1;
            t = t >> 1;
          end
      end
      c = n;
      h = nh;
    end
    for (int i = 0; i < 16; i++) begin
      r0[i] = c[i][0];
      r1[i] = c[i][1];
    end
    pp = r0 + r1;
  end
endmodule

// File: rtl/dadda_mul16_seq.sv
// dadda_mul16_seq: 16x16 unsigned multiplier sequencing four 8x8 Dadda products into a 32-bit accumulator.
module dadda_mul16_seq
  import dadda_pkg::*;
#(
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] p,
  output logic        busy
);
  state_t state;
  logic [$clog2(MUL_STEPS)-1:0] step;
  logic [ACC_W-1:0] acc;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [15:0] pp;
  logic [ACC_W-1:0] addend;
  // step wraps back to 0 after the last product, so IDLE/DONE see the step-0 selection
  assign op_a = A_HI[step] ? a_q[15:8] : a_q[7:0];
  assign op_b = B_HI[step] ? b_q[15:8] : b_q[7:0];
  assign addend = {16'b0, pp} << STEP_SHIFT[step];
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign out_valid = state == DONE;
  assign p = acc;
  dadda_8 u_core (
    .x  (op_a),
    .y  (op_b),
    .pp (pp)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step <= '0;
      acc <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q <= a;
          b_q <= b;
          acc <= '0;
          step <= '0;
          state <= (ZERO_SKIP && (a == 16'd0 || b == 16'd0)) ? DONE : MUL;
        end
        MUL: begin
          acc <= acc + addend;
          step <= step + 1'b1;
          if (&step) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
